// File: rtl/gen_test_stream_pkg.sv
// Shared event-builder / front-end link test-stream constants and the
// one-hot state encoding of the test-stream generator.
package gen_test_stream_pkg;

   localparam int          TEST_WORD_W       = 24;
   localparam logic [23:0] TEST_FIRST_WORD   = 24'hFFFFFF;
   localparam logic [23:0] TEST_LAST_WORD    = 24'h000001;
   localparam logic [11:0] TEST_ABORT_CYCLES = 12'hFFF;

   typedef enum logic [3:0] {
      ST_IDLE = 4'b0001,
      ST_GAP  = 4'b0010,
      ST_SEND = 4'b0100,
      ST_FIN  = 4'b1000
   } gts_state_e;

endpackage

// File: rtl/gen_test_stream_serializer.sv
// Word serializer: shifts a loaded (optionally corrupted) word out MSB first
// and flags the cycle in which the final bit is presented.
module test_word_serializer #(
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] word,
   input  logic [W-1:0] inj_mask,
   input  logic         shift_en,
   output logic         ser_out,
   output logic         last_bit
);

   localparam int CW = $clog2(W);

   logic [W-1:0]  sr_q, sr_d;
   logic [CW-1:0] bit_cnt_q, bit_cnt_d;

   assign ser_out  = sr_q[W-1];
   assign last_bit = (bit_cnt_q == CW'(W-1));

   // Load wins over shift so the next word follows the last bit with no gap.
   always_comb begin
      sr_d      = sr_q;
      bit_cnt_d = bit_cnt_q;
      if (load) begin
         sr_d      = word ^ inj_mask;
         bit_cnt_d = '0;
      end else if (shift_en && !last_bit) begin
         sr_d      = {sr_q[W-2:0], 1'b0};
         bit_cnt_d = bit_cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q      <= '0;
         bit_cnt_q <= '0;
      end else begin
         sr_q      <= sr_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

endmodule

// File: rtl/gen_test_stream.sv
// Link test-stream generator: after a programmable gap, sends a descending
// run of words from 24'hFFFFFF to LAST_WORD, with optional single-bit corruption.
module gen_test_stream
   import gen_test_stream_pkg::*;
#(
   parameter int                WORD_W    = TEST_WORD_W,
   parameter logic [WORD_W-1:0] LAST_WORD = TEST_LAST_WORD
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Start,
   input  logic [11:0]       StartDly,
   input  logic              InjErr,
   input  logic [WORD_W-1:0] ErrWord,
   input  logic [4:0]        ErrBit,
   output logic              Stream,
   output logic              Busy,
   output logic              Done,
   output logic [WORD_W-1:0] WordCnt
);

   gts_state_e        state_q, state_d;
   logic [11:0]       start_dly_q, start_dly_d;
   logic [11:0]       dly_cnt_q, dly_cnt_d;
   logic              inj_en_q, inj_en_d;
   logic [WORD_W-1:0] err_word_q, err_word_d;
   logic [4:0]        err_bit_q, err_bit_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic [WORD_W-1:0] word_cnt_q, word_cnt_d;
   logic              stream_q, stream_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              ser_load, ser_shift, ser_out, ser_last;
   logic [WORD_W-1:0] inj_mask;

   // Mask is evaluated against the word about to be loaded; word values are
   // unique within a run, so the corruption happens at most once.
   always_comb begin
      inj_mask = '0;
      if (inj_en_q && (err_bit_q <= 5'(WORD_W-1)) && (word_d == err_word_q))
         inj_mask = WORD_W'(1) << err_bit_q;
   end

   always_comb begin
      state_d     = state_q;
      start_dly_d = start_dly_q;
      dly_cnt_d   = dly_cnt_q;
      inj_en_d    = inj_en_q;
      err_word_d  = err_word_q;
      err_bit_d   = err_bit_q;
      word_d      = word_q;
      word_cnt_d  = word_cnt_q;
      stream_d    = 1'b0;
      busy_d      = busy_q;
      done_d      = 1'b0;
      ser_load    = 1'b0;
      ser_shift   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (Start) begin
               state_d     = ST_GAP;
               start_dly_d = StartDly;
               inj_en_d    = InjErr;
               err_word_d  = ErrWord;
               err_bit_d   = ErrBit;
               word_cnt_d  = '0;
               word_d      = TEST_FIRST_WORD;
               dly_cnt_d   = '0;
               busy_d      = 1'b1;
            end
         end
         ST_GAP: begin
            ser_load = 1'b1;
            if (dly_cnt_q == start_dly_q) state_d = ST_SEND;
            else                          dly_cnt_d = dly_cnt_q + 12'd1;
         end
         ST_SEND: begin
            stream_d  = ser_out;
            ser_shift = 1'b1;
            if (ser_last) begin
               word_cnt_d = word_cnt_q + WORD_W'(1);
               if (word_q == LAST_WORD) begin
                  state_d = ST_FIN;
               end else begin
                  word_d   = word_q - WORD_W'(1);
                  ser_load = 1'b1;
               end
            end
         end
         ST_FIN: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q     <= ST_IDLE;
         start_dly_q <= '0;
         dly_cnt_q   <= '0;
         inj_en_q    <= 1'b0;
         err_word_q  <= '0;
         err_bit_q   <= '0;
         word_q      <= '0;
         word_cnt_q  <= '0;
         stream_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         start_dly_q <= start_dly_d;
         dly_cnt_q   <= dly_cnt_d;
         inj_en_q    <= inj_en_d;
         err_word_q  <= err_word_d;
         err_bit_q   <= err_bit_d;
         word_q      <= word_d;
         word_cnt_q  <= word_cnt_d;
         stream_q    <= stream_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   test_word_serializer #(.W(WORD_W)) u_ser (
      .clk      (Clock),
      .rst      (Reset),
      .load     (ser_load),
      .word     (word_d),
      .inj_mask (inj_mask),
      .shift_en (ser_shift),
      .ser_out  (ser_out),
      .last_bit (ser_last)
   );

   assign Stream  = stream_q;
   assign Busy    = busy_q;
   assign Done    = done_q;
   assign WordCnt = word_cnt_q;

endmodule

// File: tb/tb_gen_test_stream.sv
// Scoreboard bench: each Start pushes the expected per-cycle Stream/Busy/Done/WordCnt
// trace into a queue; a negedge monitor pops and compares.
module tb_gen_test_stream;

   logic        Clock, Reset, Start, InjErr, Stream, Busy, Done;
   logic [11:0] StartDly;
   logic [23:0] ErrWord, WordCnt;
   logic [4:0]  ErrBit;

   typedef struct packed {
      logic        s;
      logic        b;
      logic        d;
      logic [23:0] wc;
   } exp_t;

   exp_t exp_q[$];
   exp_t e_mon;
   int   checks = 0, failures = 0, sample_idx = 0;
   int   push_n, push_lim;

   gen_test_stream #(.LAST_WORD(24'hFFFFFC)) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .Start    (Start),
      .StartDly (StartDly),
      .InjErr   (InjErr),
      .ErrWord  (ErrWord),
      .ErrBit   (ErrBit),
      .Stream   (Stream),
      .Busy     (Busy),
      .Done     (Done),
      .WordCnt  (WordCnt)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   always @(negedge Clock) begin
      if (exp_q.size() > 0) begin
         e_mon = exp_q.pop_front();
         checks++;
         if (Stream !== e_mon.s || Busy !== e_mon.b || Done !== e_mon.d || WordCnt !== e_mon.wc) begin
            failures++;
            $display("FAIL trace[%0d] got s=%b busy=%b done=%b wc=%h, want s=%b busy=%b done=%b wc=%h",
                     sample_idx, Stream, Busy, Done, WordCnt, e_mon.s, e_mon.b, e_mon.d, e_mon.wc);
         end
         sample_idx++;
      end
   end

   function automatic void push_exp(input logic s, input logic b, input logic d, input logic [23:0] wc);
      if (push_lim < 0 || push_n < push_lim) exp_q.push_back('{s: s, b: b, d: d, wc: wc});
      push_n++;
   endfunction

   // Call with time just after a posedge; Start is sampled on the next edge.
   task automatic issue_start(input logic [11:0] dly, input logic inj, input logic [23:0] ew,
                              input logic [4:0] eb, input logic [23:0] w0, input logic [23:0] w1,
                              input logic [23:0] w2, input logic [23:0] w3,
                              input int npush, input int tail);
      logic [23:0] words [4];
      words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3;
      StartDly = dly; InjErr = inj; ErrWord = ew; ErrBit = eb; Start = 1'b1;
      @(posedge Clock);
      push_n = 0; push_lim = npush;
      for (int i = 0; i < int'(dly) + 2; i++) push_exp(1'b0, 1'b1, 1'b0, 24'd0);
      for (int w = 0; w < 4; w++)
         for (int b = 0; b < 24; b++)
            push_exp(words[w][23-b], 1'b1, 1'b0, (b == 23) ? 24'(w + 1) : 24'(w));
      push_exp(1'b0, 1'b0, 1'b1, 24'd4);
      for (int i = 0; i < tail; i++) push_exp(1'b0, 1'b0, 1'b0, 24'd4);
      #1;
      // Scramble the configuration inputs: they must already be latched.
      Start = 1'b0; StartDly = 12'd7; InjErr = 1'b1; ErrWord = 24'hFFFFFD; ErrBit = 5'd3;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() > 0 && n < 5000) begin
         @(posedge Clock);
         n++;
      end
      if (exp_q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain timeout: %0d expected samples left, want 0", exp_q.size());
         exp_q.delete();
      end
      @(posedge Clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired: got no finish, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset = 1'b1; Start = 1'b0; StartDly = '0; InjErr = 1'b0; ErrWord = '0; ErrBit = '0;
      // Reset state, including a Start coinciding with the last reset edge.
      @(posedge Clock);
      for (int i = 0; i < 3; i++) exp_q.push_back('{s: 1'b0, b: 1'b0, d: 1'b0, wc: 24'd0});
      #1;
      @(posedge Clock);
      #1 Start = 1'b1;
      @(posedge Clock);
      #1 Start = 1'b0; Reset = 1'b0;
      for (int i = 0; i < 2; i++) exp_q.push_back('{s: 1'b0, b: 1'b0, d: 1'b0, wc: 24'd0});
      drain();

      // Plain run.
      issue_start(12'd3, 1'b0, 24'h0, 5'd0, 24'hFFFFFF, 24'hFFFFFE, 24'hFFFFFD, 24'hFFFFFC, -1, 2);
      drain();
      // Bit 0 of FFFFFE inverted.
      issue_start(12'd3, 1'b1, 24'hFFFFFE, 5'd0, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFD, 24'hFFFFFC, -1, 2);
      drain();
      // ErrBit out of range disables injection.
      issue_start(12'd3, 1'b1, 24'hFFFFFE, 5'd24, 24'hFFFFFF, 24'hFFFFFE, 24'hFFFFFD, 24'hFFFFFC, -1, 2);
      drain();
      // InjErr low: matching word left alone; longer gap.
      issue_start(12'd20, 1'b0, 24'hFFFFFD, 5'd7, 24'hFFFFFF, 24'hFFFFFE, 24'hFFFFFD, 24'hFFFFFC, -1, 2);
      drain();
      // MSB of FFFFFD and bit 5 of FFFFFC.
      issue_start(12'd3, 1'b1, 24'hFFFFFD, 5'd23, 24'hFFFFFF, 24'hFFFFFE, 24'h7FFFFD, 24'hFFFFFC, -1, 2);
      drain();
      issue_start(12'd3, 1'b1, 24'hFFFFFC, 5'd5, 24'hFFFFFF, 24'hFFFFFE, 24'hFFFFFD, 24'hFFFFDC, -1, 2);
      drain();

      // Second Start during word 2 is ignored.
      issue_start(12'd3, 1'b0, 24'h0, 5'd0, 24'hFFFFFF, 24'hFFFFFE, 24'hFFFFFD, 24'hFFFFFC, -1, 2);
      repeat (40) @(posedge Clock);
      #1 Start = 1'b1; StartDly = 12'd0; InjErr = 1'b1; ErrWord = 24'hFFFFFF; ErrBit = 5'd0;
      @(posedge Clock);
      #1 Start = 1'b0;
      drain();

      // Reset while bit 10 of word 3 is on Stream, then a fresh full run.
      issue_start(12'd3, 1'b0, 24'h0, 5'd0, 24'hFFFFFF, 24'hFFFFFE, 24'hFFFFFD, 24'hFFFFFC, 64, 0);
      repeat (63) @(posedge Clock);
      #1 Reset = 1'b1;
      for (int i = 0; i < 2; i++) exp_q.push_back('{s: 1'b0, b: 1'b0, d: 1'b0, wc: 24'd0});
      @(posedge Clock);
      #1 Reset = 1'b0;
      drain();
      issue_start(12'd3, 1'b0, 24'h0, 5'd0, 24'hFFFFFF, 24'hFFFFFE, 24'hFFFFFD, 24'hFFFFFC, -1, 2);
      drain();

      // Zero gap: first bit two edges after the Start edge.
      issue_start(12'd0, 1'b0, 24'h0, 5'd0, 24'hFFFFFF, 24'hFFFFFE, 24'hFFFFFD, 24'hFFFFFC, -1, 2);
      drain();

      // Start held through Fin (ignored) into Idle re-entry (accepted).
      issue_start(12'd2, 1'b0, 24'h0, 5'd0, 24'hFFFFFF, 24'hFFFFFE, 24'hFFFFFD, 24'hFFFFFC, -1, 0);
      repeat (99) @(posedge Clock);
      #1 Start = 1'b1;
      @(posedge Clock);
      #1;
      issue_start(12'd1, 1'b1, 24'hFFFFFF, 5'd1, 24'hFFFFFD, 24'hFFFFFE, 24'hFFFFFD, 24'hFFFFFC, -1, 2);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gen_test_stream.md
Name: gen_test_stream

Overview:
- Front-end-board side generator of the link test stream consumed by the event builder's test-stream evaluator.
- On a one-cycle Start, waits a programmable idle gap, then emits a contiguous serial stream of 24-bit words, MSB first, counting down from 24'hFFFFFF to LAST_WORD. Stream then returns low.
- Optional single-bit error injection lets the link checker's error counting be exercised end to end.

Parameters:
- LAST_WORD, 24'h000001, final word value sent; must satisfy 1 <= LAST_WORD <= 24'hFFFFFF. System builds use the default; unit benches shorten the run.
- WORD_W, 24, word width; fixed by the link format, not to be overridden.

Ports:
- Clock  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- Start  in  1  one-cycle pulse that starts a test; ignored while Busy
- StartDly  in  12  idle (Stream=0) cycles between Start and the first data bit; sampled at Start
- InjErr  in  1  enable error injection; sampled at Start
- ErrWord  in  24  word value to corrupt; sampled at Start
- ErrBit  in  5  bit index to invert (23 = MSB); values > 23 disable injection; sampled at Start
- Stream  out  1  registered serial output to the link
- Busy  out  1  high from the cycle after Start until Done
- Done  out  1  one-cycle pulse after the last bit of LAST_WORD
- WordCnt  out  24  number of words fully sent in the current or last test

Behaviour:
- Reset: Stream=0, Busy=0, Done=0, WordCnt=0, State=Idle. Reset mid-test aborts immediately; Stream is 0 from the next edge.
- States (one-hot):
  - Idle: Start -> Gap. On Start, latch StartDly/InjErr/ErrWord/ErrBit, clear WordCnt, load Word=24'hFFFFFF, DlyCnt=0.
  - Gap: Stream=0; DlyCnt increments; when DlyCnt==StartDly -> Send. StartDly=0 still spends exactly one Gap cycle.
  - Send: Stream = Word[23-BitCnt] XOR inject; BitCnt 0..23. At BitCnt==23:
    - WordCnt+1.
    - If Word==LAST_WORD -> Fin; else Word-1, BitCnt=0, stay in Send.
    - No gap cycles between words.
  - Fin: Stream=0, Done=1 for one cycle, Busy=0 -> Idle.
- Timing: Start sampled high at edge T; the first data bit (MSB of 24'hFFFFFF, always 1) appears on Stream after edge T+1+StartDly+1. Stream is 0 at all other non-Send times.
- Stream is a flop output with no combinational path from any input.
- Injection: when InjErr latched, latched ErrBit <= 23, and Word==latched ErrWord, the bit at index ErrBit of that word is inverted, once only. Corrupting bit 23 of 24'hFFFFFF destroys the receiver's start bit; this is allowed and leads to the receiver timing out.
- Start while Busy is ignored. Start in the same cycle as Reset is ignored. Start during Fin is ignored; Start on the cycle Idle is re-entered is accepted.
- Word arithmetic is unsigned 24-bit; no wrap is possible because the count stops at LAST_WORD >= 1.
- The receiver aborts if no start bit arrives within 4095 cycles of its Start. Use StartDly < 4000 in system operation.

Decomposition:
- Shared package (event-builder/front-end link constants): TEST_WORD_W=24, TEST_FIRST_WORD=24'hFFFFFF, TEST_LAST_WORD=24'h000001, TEST_ABORT_CYCLES=12'hFFF, and the one-hot state encodings for this block.
- One natural sub-module: test_word_serializer. It holds the 24-bit shift register, BitCnt, and the injection XOR. Interface: Load, Word, InjMask, ShiftEn -> SerOut, LastBit.

Test Plan:
- LAST_WORD=24'hFFFFFC, StartDly=3, InjErr=0, Start pulse:
  - Stream low 4 cycles, then 96 bits FFFFFF,FFFFFE,FFFFFD,FFFFFC MSB first with no gaps.
  - Done pulses once, 1 cycle after the last bit; WordCnt=4; Busy high throughout.
- Same config, InjErr=1, ErrWord=24'hFFFFFE, ErrBit=0 -> second word received as 24'hFFFFFF; all other words unchanged.
  - Loopback into the evaluator gives Nerr=1, badTest=24'hFFFFFE.
- ErrBit=24 with InjErr=1 -> no corruption; stream identical to the first scenario.
- Second Start pulse mid-stream (during word 2) -> ignored; stream and Done timing identical to the first scenario.
- Reset asserted at bit 10 of word 3 -> Stream=0, Busy=0, WordCnt=0 next cycle; no Done. A fresh Start afterwards produces a full correct run.
- StartDly=0 -> first bit (1) on Stream exactly 2 edges after the Start edge.
  - Default LAST_WORD, loopback only: after the Done pulse, Stream, Busy and Done are all 0.
